// File: rtl/data_memory_unit.sv
// Data memory unit: fixed-latency byte/half/word load-store over a word array.
// IDLE accepts, BUSY performs the array access, DONE pulses completion.
module data_memory_unit #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_ld;
  logic          r_st;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [AW+1:0] r_a;
  logic [31:0]   r_wd;
  logic [31:0]   r_rd;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_e1;
  logic          w_ill;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [31:0]   w_wdat;
  logic [3:0]    w_mask;
  logic [31:0]   w_merged;
  logic          w_unused_a;

  // upper address bits only alias the array, they never select anything
  assign w_unused_a = ^A[31:AW+2];

  assign req_ready = (r_state == S_IDLE) && !reset;
  assign w_accept  = req_valid && req_ready;
  assign w_e1      = (r_state == S_BUSY) && !reset;
  assign done      = (r_state == S_DONE);
  assign err       = done && r_err;
  assign RD        = r_rd;

  assign w_idx  = r_a[AW+1:2];
  assign w_word = r_mem[w_idx];

  assign w_ill = (r_ld == r_st)
              || (r_size == 2'b11)
              || ((r_size == 2'b01) && r_a[0])
              || ((r_size == 2'b10) && (r_a[1:0] != 2'b00));

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state: fixed three-cycle walk once a request is taken
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_BUSY;
      S_BUSY:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // capture the request at acceptance; later input changes are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld   <= 1'b0;
      r_st   <= 1'b0;
      r_size <= 2'b00;
      r_uns  <= 1'b0;
      r_a    <= '0;
      r_wd   <= 32'h0;
    end else if (w_accept) begin
      r_ld   <= MemRead;
      r_st   <= MemWrite;
      r_size <= size;
      r_uns  <= unsigned_ld;
      r_a    <= A[AW+1:0];
      r_wd   <= WD;
    end
  end

  // little-endian lane pick and sign/zero extension for loads
  always_comb begin
    w_byte = w_word[{r_a[1:0], 3'b000} +: 8];
    w_half = r_a[1] ? w_word[31:16] : w_word[15:0];
    w_load = w_word;
    unique case (r_size)
      2'b00:   w_load = {{24{!r_uns && w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{!r_uns && w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  // store data replicated across lanes, merged under the lane mask
  always_comb begin
    w_wdat = r_wd;
    w_mask = 4'b1111;
    unique case (r_size)
      2'b00: begin
        w_wdat = {4{r_wd[7:0]}};
        w_mask = 4'b0001 << r_a[1:0];
      end
      2'b01: begin
        w_wdat = {2{r_wd[15:0]}};
        w_mask = r_a[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdat = r_wd;
        w_mask = 4'b1111;
      end
    endcase
    w_merged = w_word;
    for (int i = 0; i < 4; i++) begin
      if (w_mask[i]) w_merged[8*i +: 8] = w_wdat[8*i +: 8];
    end
  end

  // array write at E1; contents are not touched by reset
  always_ff @(posedge clk) begin
    if (w_e1 && r_st && !w_ill) r_mem[w_idx] <= w_merged;
  end

  // load data / error flag: updated at E1, held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd  <= 32'h0;
      r_err <= 1'b0;
    end else if (w_e1) begin
      r_err <= w_ill;
      if (w_ill)     r_rd <= 32'h0;
      else if (r_ld) r_rd <= w_load;
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: directed scenarios plus random traffic
// against a byte-array reference model.
module tb_data_memory_unit;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int NB    = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem_m [NB];
  logic [31:0] model_rd;

  always #5 clk = ~clk;

  data_memory_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .size(size),
    .unsigned_ld(unsigned_ld),
    .A(A),
    .WD(WD),
    .RD(RD),
    .done(done),
    .err(err)
  );

  // reference: byte-addressed memory, plain arithmetic extension
  task automatic m_apply(input logic ld, input logic st,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] e_rd, output logic e_err);
    int nb;
    int ba;
    longint v;
    bit ill;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ba = int'(a % NB);
    ill = (ld == st) || (sz == 2'd3) || ((int'(a % 4) % nb) != 0);
    if (ill) begin
      model_rd = 32'h0;
    end else if (st) begin
      for (int k = 0; k < nb; k++)
        mem_m[ba + k] = 8'((wd >> (8 * k)) & 32'hFF);
    end else begin
      v = 0;
      for (int k = 0; k < nb; k++)
        v += longint'(mem_m[ba + k]) << (8 * k);
      if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
        v -= longint'(1) << (8 * nb);
      model_rd = v[31:0];
    end
    e_rd  = model_rd;
    e_err = ill;
  endtask

  task automatic scramble();
    req_valid   = 1'($urandom());
    MemRead     = 1'($urandom());
    MemWrite    = 1'($urandom());
    size        = 2'($urandom());
    unsigned_ld = 1'($urandom());
    A           = $urandom();
    WD          = $urandom();
  endtask

  // one full request; called #1 after an edge with the DUT idle
  task automatic xact(input logic ld, input logic st,
                      input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd_o, output logic err_o,
                      output logic lat_ok);
    lat_ok = (req_ready === 1'b1) && (done === 1'b0);
    req_valid = 1'b1;
    MemRead = ld; MemWrite = st; size = sz;
    unsigned_ld = uns; A = a; WD = wd;
    @(posedge clk); #1;
    lat_ok = lat_ok && (req_ready === 1'b0) && (done === 1'b0);
    scramble();
    @(posedge clk); #1;
    lat_ok = lat_ok && (done === 1'b1) && (req_ready === 1'b0);
    rd_o = RD;
    err_o = err;
    scramble();
    @(posedge clk); #1;
    lat_ok = lat_ok && (done === 1'b0) && (err === 1'b0)
          && (req_ready === 1'b1);
    req_valid = 1'b0;
  endtask

  task automatic step(input logic ld, input logic st,
                      input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] e_rd, output logic e_err,
                      output logic [31:0] g_rd, output logic g_err,
                      output logic lat);
    m_apply(ld, st, sz, uns, a, wd, e_rd, e_err);
    xact(ld, st, sz, uns, a, wd, g_rd, g_err, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
    size = 2'd2; unsigned_ld = 1'b0; A = 32'h0; WD = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0
          || RD !== 32'h0) begin
        errors++;
        $display("FAIL reset_state ready=%b done=%b err=%b RD=%h want 0 0 0 0",
                 req_ready, done, err, RD);
      end
    end
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release ready=%b want 1", req_ready);
    end
    model_rd = 32'h0;
  endtask

  task automatic test_word_roundtrip();
    logic [31:0] e, g; logic ee, ge, lat;
    step(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, e, ee, g, ge, lat);
    step(1, 0, 2'd2, 0, 32'h10, 32'h0, e, ee, g, ge, lat);
    checks++;
    if (g !== 32'hDEADBEEF || ge !== 1'b0 || !lat) begin
      errors++;
      $display("FAIL word_roundtrip RD=%h err=%b lat=%b want DEADBEEF 0 1",
               g, ge, lat);
    end
  endtask

  task automatic test_extension();
    logic [31:0] e, g; logic ee, ge, lat;
    logic [31:0] adr [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
    logic [1:0]  szs [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        un  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080,
                             32'h00007F01, 32'hFFFF80FF};
    step(0, 1, 2'd2, 0, 32'h10, 32'h80FF7F01, e, ee, g, ge, lat);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, szs[i], un[i], adr[i], 32'h0, e, ee, g, ge, lat);
      checks++;
      if (g !== exp[i] || ge !== 1'b0 || !lat) begin
        errors++;
        $display("FAIL extension_%0d RD=%h err=%b lat=%b want %h 0 1",
                 i, g, ge, lat, exp[i]);
      end
    end
  endtask

  task automatic test_lane_store();
    logic [31:0] e, g, prev; logic ee, ge, lat;
    step(0, 1, 2'd2, 0, 32'h20, 32'h11223344, e, ee, g, ge, lat);
    prev = model_rd;
    step(0, 1, 2'd0, 0, 32'h21, 32'h000000AB, e, ee, g, ge, lat);
    checks++;
    if (g !== prev || ge !== 1'b0 || !lat) begin
      errors++;
      $display("FAIL store_holds_rd RD=%h err=%b want %h 0", g, ge, prev);
    end
    step(1, 0, 2'd2, 0, 32'h20, 32'h0, e, ee, g, ge, lat);
    checks++;
    if (g !== 32'h1122AB44 || ge !== 1'b0) begin
      errors++;
      $display("FAIL byte_store RD=%h want 1122AB44", g);
    end
    step(0, 1, 2'd1, 0, 32'h22, 32'h0000CDEF, e, ee, g, ge, lat);
    step(1, 0, 2'd2, 0, 32'h20, 32'h0, e, ee, g, ge, lat);
    checks++;
    if (g !== 32'hCDEFAB44 || ge !== 1'b0) begin
      errors++;
      $display("FAIL half_store RD=%h want CDEFAB44", g);
    end
  endtask

  task automatic test_errors();
    logic [31:0] e, g; logic ee, ge, lat;
    logic        ld [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        st [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  sz [5] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2};
    logic [31:0] ad [5] = '{32'h22, 32'h23, 32'h20, 32'h20, 32'h20};
    for (int i = 0; i < 5; i++) begin
      step(ld[i], st[i], sz[i], 0, ad[i], 32'h12345678, e, ee, g, ge, lat);
      checks++;
      if (g !== 32'h0 || ge !== 1'b1 || !lat) begin
        errors++;
        $display("FAIL illegal_%0d RD=%h err=%b lat=%b want 0 1 1",
                 i, g, ge, lat);
      end
    end
    step(1, 0, 2'd2, 0, 32'h20, 32'h0, e, ee, g, ge, lat);
    checks++;
    if (g !== 32'hCDEFAB44) begin
      errors++;
      $display("FAIL illegal_no_write RD=%h want CDEFAB44", g);
    end
  endtask

  task automatic test_handshake();
    int acc = 0;
    int dn = 0;
    logic [31:0] e; logic ee;
    req_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
    size = 2'd2; unsigned_ld = 1'b0; A = 32'h10; WD = 32'h0;
    for (int i = 0; i < 9; i++) begin
      if (req_ready) acc++;
      if (done) dn++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    m_apply(1, 0, 2'd2, 0, 32'h10, 32'h0, e, ee);
    checks++;
    if (acc != 3 || dn != 3 || RD !== e) begin
      errors++;
      $display("FAIL back_to_back acc=%0d done=%0d RD=%h want 3 3 %h",
               acc, dn, RD, e);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e, g, d; logic ee, ge, lat;
    d = $urandom();
    step(0, 1, 2'd2, 0, 32'h100, d, e, ee, g, ge, lat);
    step(1, 0, 2'd2, 0, 32'h000, 32'h0, e, ee, g, ge, lat);
    checks++;
    if (g !== d || ge !== 1'b0) begin
      errors++;
      $display("FAIL addr_wrap RD=%h want %h", g, d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e, g; logic ee, ge, lat;
    int seen = 0;
    step(0, 1, 2'd2, 0, 32'h30, 32'h0, e, ee, g, ge, lat);
    req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1;
    size = 2'd2; A = 32'h30; WD = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_rd = 32'h0;
    for (int i = 0; i < 3; i++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0 || RD !== 32'h0) begin
      errors++;
      $display("FAIL reset_at_e1 dones=%0d RD=%h want 0 0", seen, RD);
    end
    step(1, 0, 2'd2, 0, 32'h30, 32'h0, e, ee, g, ge, lat);
    checks++;
    if (g !== 32'h0 || ge !== 1'b0) begin
      errors++;
      $display("FAIL aborted_store RD=%h want 00000000", g);
    end
    req_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
    size = 2'd2; A = 32'h10; WD = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b0 || RD !== 32'h0) begin
      errors++;
      $display("FAIL reset_at_e2 done=%b ready=%b RD=%h want 0 0 0",
               done, req_ready, RD);
    end
    reset = 1'b0;
    model_rd = 32'h0;
  endtask

  task automatic test_random();
    logic [31:0] e, g, a, wd; logic ee, ge, lat, ld, st, un;
    logic [1:0] sz;
    for (int i = 0; i < DEPTH; i++)
      step(0, 1, 2'd2, 0, 32'(4 * i), $urandom(), e, ee, g, ge, lat);
    for (int i = 0; i < 300; i++) begin
      ld = 1'($urandom());
      st = ($urandom_range(0, 9) == 0) ? ld : !ld;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      un = 1'($urandom());
      a  = $urandom();
      if ($urandom_range(0, 3) != 0)
        a = (sz == 2'd1) ? (a & ~32'h1) : (sz == 2'd2) ? (a & ~32'h3) : a;
      wd = $urandom();
      step(ld, st, sz, un, a, wd, e, ee, g, ge, lat);
      checks++;
      if (g !== e || ge !== ee || !lat) begin
        errors++;
        $display("FAIL random_%0d A=%h RD=%h err=%b lat=%b want %h %b 1",
                 i, a, g, ge, lat, e, ee);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_roundtrip();
    test_extension();
    test_lane_store();
    test_errors();
    test_handshake();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
